// File: rtl/projection_bbox_gen2_if.sv
`default_nettype none
// ============================================================================
// Module      : projection_bbox_gen2_if
// Description : Pixel stream and bounding-box result bundle for
//               projection_bbox_gen2.
// Revision    : 1.0 - initial release
// ============================================================================
interface projection_bbox_gen2_if;
    logic        en;
    logic [23:0] i_binary;
    logic        i_vs;
    logic        i_de;
    logic [11:0] i_hcount;
    logic [11:0] i_vcount;
    logic [11:0] hcount_l;
    logic [11:0] hcount_r;
    logic [11:0] vcount_l;
    logic [11:0] vcount_r;
    logic        o_valid;
    logic        o_found;
    logic        o_busy;
    logic        o_overrun;

    modport master (
        output en, i_binary, i_vs, i_de, i_hcount, i_vcount,
        input  hcount_l, hcount_r, vcount_l, vcount_r,
        input  o_valid, o_found, o_busy, o_overrun
    );

    modport slave (
        input  en, i_binary, i_vs, i_de, i_hcount, i_vcount,
        output hcount_l, hcount_r, vcount_l, vcount_r,
        output o_valid, o_found, o_busy, o_overrun
    );
endinterface
`default_nettype wire

// File: rtl/projection_bbox_gen2.sv
`default_nettype none
// ============================================================================
// Module      : projection_bbox_gen2
// Description : Per-frame column/row projection bounding-box extractor with
//               run-length noise rejection and shrunk box output.
// Revision    : 1.0 - initial release
// ============================================================================
module projection_bbox_gen2 #(
    parameter int          IMG_WIDTH   = 1024,
    parameter int          IMG_HEIGHT  = 768,
    parameter logic [23:0] MATCH_COLOR = 24'h333333,
    parameter int          BORDER      = 4,
    parameter int          MIN_RUN     = 3,
    parameter int          SHRINK_X    = 25,
    parameter int          SHRINK_Y    = 30
) (
    input  wire logic              pixelclk,
    input  wire logic              reset,
    projection_bbox_gen2_if.slave  bus
);
    localparam int          c_N      = (IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT;
    localparam int          c_HAW    = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int          c_VAW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [12:0] c_W      = 13'(IMG_WIDTH);
    localparam logic [12:0] c_H      = 13'(IMG_HEIGHT);
    localparam logic [12:0] c_NN     = 13'(c_N);
    localparam logic [12:0] c_MIN    = 13'(MIN_RUN);
    localparam logic [12:0] c_SX2    = 13'(2 * SHRINK_X);
    localparam logic [12:0] c_SY2    = 13'(2 * SHRINK_Y);
    localparam logic [11:0] c_BORDER = 12'(BORDER);
    localparam logic [11:0] c_SX     = 12'(SHRINK_X);
    localparam logic [11:0] c_SY     = 12'(SHRINK_Y);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_ACCUM   = 2'd1,
        S_SCAN    = 2'd2,
        S_PUBLISH = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [12:0] r_cnt;
    logic        r_vs_d, r_vs_rise;
    logic        r_rd_vld;
    logic [12:0] r_rd_addr;
    logic        r_overrun;
    logic        w_accept, w_clear, w_scan_done;

    logic             r_hmem [IMG_WIDTH];
    logic             r_vmem [IMG_HEIGHT];
    logic             r_hq, r_vq;
    logic             w_h_we, w_h_wd, w_v_we, w_v_wd;
    logic [c_HAW-1:0] w_h_wa;
    logic [c_VAW-1:0] w_v_wa;

    logic [12:0] r_h_len, r_v_len;
    logic [11:0] r_h_start, r_h_s, r_h_e, r_v_start, r_v_s, r_v_e;
    logic        r_h_found, r_v_found;
    logic        w_h_bitvld, w_h_last, w_v_bitvld, w_v_last;
    logic [11:0] w_h_diff, w_v_diff;

    logic [11:0] r_hl, r_hr, r_vl, r_vr;
    logic        r_valid, r_found;

    always_ff @(posedge pixelclk) begin
        if (reset) r_state <= S_INIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:    if (r_cnt == c_NN - 13'd1) w_state_nxt = S_ACCUM;
            S_ACCUM:   if (r_vs_rise)              w_state_nxt = S_SCAN;
            S_SCAN:    if (r_cnt == c_NN + 13'd1) w_state_nxt = S_PUBLISH;
            default:                               w_state_nxt = S_ACCUM;
        endcase
    end

    assign w_scan_done = (r_state == S_SCAN) && (r_cnt == c_NN + 13'd1);
    assign w_clear     = (r_state == S_INIT) || ((r_state == S_SCAN) && (r_cnt < c_NN));
    assign w_accept    = (r_state == S_ACCUM) && bus.en && bus.i_de &&
                         (bus.i_binary == MATCH_COLOR) &&
                         (bus.i_hcount >= c_BORDER) && ({1'b0, bus.i_hcount} < c_W) &&
                         (bus.i_vcount >= c_BORDER) && ({1'b0, bus.i_vcount} < c_H);

    // Clearing (INIT, SCAN) and accumulation (ACCUM) never overlap, so one write port suffices.
    always_comb begin
        w_h_we = 1'b0;
        w_h_wd = 1'b0;
        w_h_wa = '0;
        w_v_we = 1'b0;
        w_v_wd = 1'b0;
        w_v_wa = '0;
        if (w_clear) begin
            w_h_we = (r_cnt < c_W);
            w_h_wa = r_cnt[c_HAW-1:0];
            w_v_we = (r_cnt < c_H);
            w_v_wa = r_cnt[c_VAW-1:0];
        end else if (w_accept) begin
            w_h_we = 1'b1;
            w_h_wd = 1'b1;
            w_h_wa = bus.i_hcount[c_HAW-1:0];
            w_v_we = 1'b1;
            w_v_wd = 1'b1;
            w_v_wa = bus.i_vcount[c_VAW-1:0];
        end
    end

    always_ff @(posedge pixelclk) begin
        if (w_h_we) r_hmem[w_h_wa] <= w_h_wd;
        if (w_v_we) r_vmem[w_v_wa] <= w_v_wd;
        r_hq <= (r_cnt < c_W) ? r_hmem[r_cnt[c_HAW-1:0]] : 1'b0;
        r_vq <= (r_cnt < c_H) ? r_vmem[r_cnt[c_VAW-1:0]] : 1'b0;
    end

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_vs_d    <= 1'b0;
            r_vs_rise <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_addr <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_cnt     <= (w_state_nxt != r_state || r_state == S_ACCUM || r_state == S_PUBLISH)
                         ? 13'd0 : r_cnt + 13'd1;
            r_vs_d    <= bus.i_vs;
            r_vs_rise <= bus.i_vs && !r_vs_d && (r_state == S_ACCUM);
            r_rd_vld  <= (r_state == S_SCAN) && (r_cnt < c_NN);
            r_rd_addr <= r_cnt;
            r_overrun <= bus.i_de && (r_state == S_INIT || r_state == S_SCAN);
        end
    end

    assign w_h_bitvld = r_rd_vld && (r_rd_addr < c_W);
    assign w_h_last   = (r_rd_addr == c_W - 13'd1);
    assign w_v_bitvld = r_rd_vld && (r_rd_addr < c_H);
    assign w_v_last   = (r_rd_addr == c_H - 13'd1);

    // Run trackers stay in reset throughout ACCUM and lock after the first qualifying run.
    always_ff @(posedge pixelclk) begin
        if (reset || r_state == S_ACCUM) begin
            r_h_len <= '0; r_h_start <= '0; r_h_s <= '0; r_h_e <= '0; r_h_found <= 1'b0;
        end else if (w_h_bitvld && !r_h_found) begin
            if (r_hq) begin
                if (r_h_len == 13'd0) r_h_start <= r_rd_addr[11:0];
                r_h_len <= r_h_len + 13'd1;
                if (w_h_last && (r_h_len + 13'd1 >= c_MIN)) begin
                    r_h_found <= 1'b1;
                    r_h_s     <= (r_h_len == 13'd0) ? r_rd_addr[11:0] : r_h_start;
                    r_h_e     <= r_rd_addr[11:0];
                end
            end else begin
                r_h_len <= '0;
                if (r_h_len >= c_MIN) begin
                    r_h_found <= 1'b1;
                    r_h_s     <= r_h_start;
                    r_h_e     <= r_rd_addr[11:0] - 12'd1;
                end
            end
        end
    end

    always_ff @(posedge pixelclk) begin
        if (reset || r_state == S_ACCUM) begin
            r_v_len <= '0; r_v_start <= '0; r_v_s <= '0; r_v_e <= '0; r_v_found <= 1'b0;
        end else if (w_v_bitvld && !r_v_found) begin
            if (r_vq) begin
                if (r_v_len == 13'd0) r_v_start <= r_rd_addr[11:0];
                r_v_len <= r_v_len + 13'd1;
                if (w_v_last && (r_v_len + 13'd1 >= c_MIN)) begin
                    r_v_found <= 1'b1;
                    r_v_s     <= (r_v_len == 13'd0) ? r_rd_addr[11:0] : r_v_start;
                    r_v_e     <= r_rd_addr[11:0];
                end
            end else begin
                r_v_len <= '0;
                if (r_v_len >= c_MIN) begin
                    r_v_found <= 1'b1;
                    r_v_s     <= r_v_start;
                    r_v_e     <= r_rd_addr[11:0] - 12'd1;
                end
            end
        end
    end

    assign w_h_diff = r_h_e - r_h_s;
    assign w_v_diff = r_v_e - r_v_s;

    // Result registers load on the SCAN->PUBLISH edge, so o_valid is high for the PUBLISH cycle.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            r_hl <= '0; r_hr <= '0; r_vl <= '0; r_vr <= '0;
            r_valid <= 1'b0;
            r_found <= 1'b0;
        end else begin
            r_valid <= w_scan_done;
            if (w_scan_done) begin
                r_found <= r_h_found && r_v_found;
                if (r_h_found && r_v_found) begin
                    r_hl <= ({1'b0, w_h_diff} < c_SX2) ? r_h_s : r_h_s + c_SX;
                    r_hr <= ({1'b0, w_h_diff} < c_SX2) ? r_h_e : r_h_e - c_SX;
                    r_vl <= ({1'b0, w_v_diff} < c_SY2) ? r_v_s : r_v_s + c_SY;
                    r_vr <= ({1'b0, w_v_diff} < c_SY2) ? r_v_e : r_v_e - c_SY;
                end
            end
        end
    end

    assign bus.hcount_l  = r_hl;
    assign bus.hcount_r  = r_hr;
    assign bus.vcount_l  = r_vl;
    assign bus.vcount_r  = r_vr;
    assign bus.o_valid   = r_valid;
    assign bus.o_found   = r_found;
    assign bus.o_busy    = (r_state == S_INIT) || (r_state == S_SCAN);
    assign bus.o_overrun = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_projection_bbox_gen2.sv
`default_nettype none
// ============================================================================
// Module      : tb_projection_bbox_gen2
// Description : Directed self-checking bench for projection_bbox_gen2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_projection_bbox_gen2;
    localparam logic [23:0] c_MATCH = 24'h333333;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    projection_bbox_gen2_if bus ();

    projection_bbox_gen2 #(
        .IMG_WIDTH  (64),
        .IMG_HEIGHT (48),
        .MATCH_COLOR(c_MATCH),
        .BORDER     (4),
        .MIN_RUN    (3),
        .SHRINK_X   (2),
        .SHRINK_Y   (2)
    ) dut (
        .pixelclk(clk),
        .reset   (rst),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [48:0] box_now();
        return {bus.o_found, bus.hcount_l, bus.hcount_r, bus.vcount_l, bus.vcount_r};
    endfunction

    task automatic pix(input int x, input int y);
        bus.i_de     = 1'b1;
        bus.i_binary = c_MATCH;
        bus.i_hcount = 12'(x);
        bus.i_vcount = 12'(y);
        tick();
        bus.i_de     = 1'b0;
    endtask

    task automatic rect(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                pix(x, y);
    endtask

    // Raises i_vs, returns edges from the sampling edge T to the o_valid pulse.
    task automatic end_frame(output int lat, output logic one_cycle);
        lat       = -1;
        one_cycle = 1'b0;
        bus.i_vs  = 1'b1;
        tick();
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (bus.o_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        tick();
        one_cycle = (bus.o_valid === 1'b0);
        bus.i_vs  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int   busy_cnt = 0;
        int   ov_cnt   = 0;
        int   lat;
        logic one;
        rst = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({box_now(), bus.o_valid, bus.o_overrun} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {box_now(), bus.o_valid, bus.o_overrun});
        end
        n_tests++;
        if (bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 1", bus.o_busy);
        end
        rst          = 1'b0;
        bus.i_de     = 1'b1;
        bus.i_binary = c_MATCH;
        bus.i_hcount = 12'd10;
        bus.i_vcount = 12'd10;
        if (bus.o_busy === 1'b1) busy_cnt++;
        for (int k = 1; k <= 65; k++) begin
            tick();
            if (bus.o_busy === 1'b1) busy_cnt++;
            if (bus.o_overrun === 1'b1) ov_cnt++;
            if (k == 64) bus.i_de = 1'b0;
        end
        n_tests++;
        if (busy_cnt != 64) begin
            n_fail++;
            $display("FAIL init_busy_cycles: got %0d expected 64", busy_cnt);
        end
        n_tests++;
        if (ov_cnt != 64) begin
            n_fail++;
            $display("FAIL init_overruns: got %0d expected 64", ov_cnt);
        end
        end_frame(lat, one);
        n_tests++;
        if (box_now() !== 49'd0) begin
            n_fail++;
            $display("FAIL first_frame_box: got %h expected 0", box_now());
        end
    endtask

    task automatic test_rect();
        int   lat;
        logic one;
        rect(10, 20, 5, 15);
        end_frame(lat, one);
        n_tests++;
        if (lat != 67) begin
            n_fail++;
            $display("FAIL rect_latency: got %0d expected 67", lat);
        end
        n_tests++;
        if (one !== 1'b1) begin
            n_fail++;
            $display("FAIL rect_valid_width: got %b expected 1", one);
        end
        n_tests++;
        if (box_now() !== {1'b1, 12'd12, 12'd18, 12'd7, 12'd13}) begin
            n_fail++;
            $display("FAIL rect_box: got %h expected %h", box_now(), {1'b1, 12'd12, 12'd18, 12'd7, 12'd13});
        end
    endtask

    task automatic test_noise();
        int   lat;
        logic one;
        rect(10, 20, 5, 15);
        pix(30, 30);
        pix(2, 20);
        end_frame(lat, one);
        n_tests++;
        if (box_now() !== {1'b1, 12'd12, 12'd18, 12'd7, 12'd13}) begin
            n_fail++;
            $display("FAIL noise_box: got %h expected %h", box_now(), {1'b1, 12'd12, 12'd18, 12'd7, 12'd13});
        end
    endtask

    task automatic test_empty();
        int   lat;
        logic one;
        end_frame(lat, one);
        n_tests++;
        if (lat != 67) begin
            n_fail++;
            $display("FAIL empty_valid: got latency %0d expected 67", lat);
        end
        n_tests++;
        if (box_now() !== {1'b0, 12'd12, 12'd18, 12'd7, 12'd13}) begin
            n_fail++;
            $display("FAIL empty_box: got %h expected %h", box_now(), {1'b0, 12'd12, 12'd18, 12'd7, 12'd13});
        end
    endtask

    task automatic test_edge();
        int   lat;
        logic one;
        rect(60, 63, 44, 47);
        end_frame(lat, one);
        n_tests++;
        if (box_now() !== {1'b1, 12'd60, 12'd63, 12'd44, 12'd47}) begin
            n_fail++;
            $display("FAIL edge_box: got %h expected %h", box_now(), {1'b1, 12'd60, 12'd63, 12'd44, 12'd47});
        end
    endtask

    task automatic test_overrun();
        int   lat = -1;
        int   ov  = 0;
        logic one;
        bus.i_vs = 1'b1;
        tick();
        for (int k = 1; k <= 200; k++) begin
            if (k == 5) begin
                bus.i_de     = 1'b1;
                bus.i_binary = c_MATCH;
                bus.i_hcount = 12'd9;
                bus.i_vcount = 12'd4;
            end
            tick();
            bus.i_de = 1'b0;
            if (bus.o_overrun === 1'b1) ov++;
            if (bus.o_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_tests++;
        if (ov != 1) begin
            n_fail++;
            $display("FAIL scan_overrun_count: got %0d expected 1", ov);
        end
        n_tests++;
        if (lat != 67 || box_now() !== {1'b0, 12'd60, 12'd63, 12'd44, 12'd47}) begin
            n_fail++;
            $display("FAIL scan_overrun_box: got lat %0d box %h expected lat 67 box %h",
                     lat, box_now(), {1'b0, 12'd60, 12'd63, 12'd44, 12'd47});
        end
        tick();
        bus.i_vs = 1'b0;
        tick();
        rect(10, 20, 5, 15);
        end_frame(lat, one);
        n_tests++;
        if (box_now() !== {1'b1, 12'd12, 12'd18, 12'd7, 12'd13}) begin
            n_fail++;
            $display("FAIL no_stale_box: got %h expected %h", box_now(), {1'b1, 12'd12, 12'd18, 12'd7, 12'd13});
        end
    endtask

    task automatic test_enable();
        int   lat;
        logic one;
        bus.en = 1'b0;
        rect(10, 20, 5, 15);
        end_frame(lat, one);
        bus.en = 1'b1;
        n_tests++;
        if (lat != 67 || box_now() !== {1'b0, 12'd12, 12'd18, 12'd7, 12'd13}) begin
            n_fail++;
            $display("FAIL en_low_box: got lat %0d box %h expected lat 67 box %h",
                     lat, box_now(), {1'b0, 12'd12, 12'd18, 12'd7, 12'd13});
        end
    endtask

    task automatic test_reset_mid_scan();
        int   lat;
        logic one;
        rect(30, 40, 20, 30);
        bus.i_vs = 1'b1;
        tick();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({box_now(), bus.o_valid, bus.o_busy} !== {49'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_scan_reset: got %h expected %h", {box_now(), bus.o_valid, bus.o_busy}, {49'd0, 1'b0, 1'b1});
        end
        rst      = 1'b0;
        bus.i_vs = 1'b0;
        repeat (64) tick();
        n_tests++;
        if (bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reinit_done: got busy %b expected 0", bus.o_busy);
        end
        rect(10, 20, 5, 15);
        end_frame(lat, one);
        n_tests++;
        if (box_now() !== {1'b1, 12'd12, 12'd18, 12'd7, 12'd13}) begin
            n_fail++;
            $display("FAIL after_reset_box: got %h expected %h", box_now(), {1'b1, 12'd12, 12'd18, 12'd7, 12'd13});
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b1;
        bus.i_binary = '0;
        bus.i_vs     = 1'b0;
        bus.i_de     = 1'b0;
        bus.i_hcount = '0;
        bus.i_vcount = '0;
        test_reset();
        test_rect();
        test_noise();
        test_empty();
        test_edge();
        test_overrun();
        test_enable();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/projection_bbox_gen2.md
# projection_bbox_gen2

Parametrised per-frame projection bounding-box extractor for the ISP tracking path. It marks the columns and rows containing pixels of a target colour during the active frame. In vertical blanking it scans both projections, rejects runs shorter than a minimum length, and publishes a shrunk bounding box of the first qualifying run on each axis. It replaces the fixed five-frame-cycle projection block with a result on every frame, separate width and height, noise rejection and status outputs.

## Interface
- IMG_WIDTH, 1024: active columns; 1 to 4096.
- IMG_HEIGHT, 768: active rows; 1 to 4096.
- MATCH_COLOR, 24'h333333: pixel value counted as target.
- BORDER, 4: pixels with hcount < BORDER or vcount < BORDER are ignored.
- MIN_RUN, 3: minimum run length accepted as an object; 1 or more.
- SHRINK_X, 25: inward shrink applied to horizontal run ends.
- SHRINK_Y, 30: inward shrink applied to vertical run ends.
- pixelclk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  when low, pixels are not accumulated; scanning and publishing are unaffected.
- i_binary  in  24  pixel value, qualified by i_de.
- i_vs  in  1  frame sync, active high; its rising edge ends the frame.
- i_de  in  1  active-pixel qualifier.
- i_hcount  in  12  column of the current pixel.
- i_vcount  in  12  row of the current pixel.
- hcount_l, hcount_r, vcount_l, vcount_r  out  12 each  published box: left, right, top, bottom.
- o_valid  out  1  one-cycle pulse when a result is published.
- o_found  out  1  1 when both axes found a qualifying run in the last published frame.
- o_busy  out  1  high in INIT and SCAN.
- o_overrun  out  1  one-cycle pulse for each pixel dropped because the block was busy.

## Operation
- Storage: two 1-bit occupancy memories, H (IMG_WIDTH deep) and V (IMG_HEIGHT deep). Each has one write port and a registered read port with 1-cycle latency. N = max(IMG_WIDTH, IMG_HEIGHT).
- State machine: INIT -> ACCUM -> SCAN -> PUBLISH -> ACCUM.
- INIT:
  - Entered on reset.
  - Writes 0 to addresses 0..N-1 of both memories; addresses beyond a memory's depth are skipped.
  - Lasts N cycles, then moves to ACCUM.
- ACCUM:
  - A pixel is accepted when en && i_de && i_binary == MATCH_COLOR && BORDER <= i_hcount < IMG_WIDTH && BORDER <= i_vcount < IMG_HEIGHT.
  - An accepted pixel writes 1 to H[i_hcount] and to V[i_vcount].
  - A registered rising edge of i_vs moves to SCAN.
- SCAN:
  - Address counter a runs 0..N-1 on both memories in parallel.
  - Each read location is written back to 0 in the same pass, so the memories are clean for the next frame.
  - Per axis, track run_start and run_len. A run closes on a 0 bit or at the last valid address of that axis.
  - The first closed run with run_len >= MIN_RUN is latched as (s, e) on that axis. Later runs are ignored.
  - After the last read returns (2 pipeline cycles), move to PUBLISH.
- PUBLISH (one cycle):
  - If both axes found a run: hcount_l = s+SHRINK_X, hcount_r = e-SHRINK_X, and likewise on the vertical axis with SHRINK_Y.
  - Where e-s < 2*SHRINK on an axis, that axis is reported unshrunk: l = s, r = e.
  - If both found: o_found = 1. Otherwise o_found = 0 and all four coordinate outputs hold their previous values.
  - o_valid = 1 this cycle.
- Arithmetic: all sums and differences are 12-bit, with no wrap possible under the parameter limits.
- Pixels with i_de high during INIT or SCAN are not written and pulse o_overrun.
- Further i_vs rising edges during SCAN or PUBLISH are ignored.

## Timing
- Reset values: all coordinate outputs 0, o_valid 0, o_found 0, o_overrun 0, o_busy 1 (INIT).
- Reset asserted mid-SCAN abandons the scan and restarts INIT. Published outputs return to reset values.
- Pixel write: 1 cycle after the pixel is presented.
- Latency: the i_vs rising edge is sampled at cycle T. SCAN spans T+1..T+N+2, and o_valid pulses at T+N+3.
- Outputs change only in the PUBLISH cycle and are stable between pulses.
- Required vertical blanking after the i_vs rise: at least N+4 cycles. Shorter blanking produces overrun drops but never corrupts the result being scanned.
- The pixel on the cycle that i_vs rises is still accumulated if i_de is high.

## Test plan
Common settings: W=64, H=48, BORDER=4, MIN_RUN=3, SHRINK_X=SHRINK_Y=2.
- Reset, then hold i_de=1 with matching pixels for 64 cycles -> o_busy high for 64 cycles, 64 o_overrun pulses, first frame result found=0.
- Target rectangle cols 10..20, rows 5..15 -> o_valid at T+67; found=1, l=12, r=18, t=7, b=13.
- Same rectangle plus an isolated pixel at (30,30) and a pixel at (2,20) -> same box (run of 1 rejected, border pixel ignored).
- Empty frame after the previous one -> o_valid pulses, found=0, coordinates stay 12/18/7/13.
- Rectangle cols 60..63, rows 44..47 -> runs close at the axis ends, unshrunk: l=60, r=63, t=44, b=47.
- Matching pixel with i_de during SCAN, then the rectangle next frame -> one o_overrun pulse, correct box next frame (no stale bits); en=0 for a full frame -> found=0.
